// File: rtl/jtframe_sdram_pkg.sv
// ---------------------------------------------------------------------------
// jtframe_sdram_pkg
// Shared definitions for the 64-bit SDRAM controller refresh scheduler.
//   CMD_*          : SDRAM command encodings as {/CS,/RAS,/CAS,/WE}
//   rfsh_state_t   : refresh scheduler FSM states
//   max2()         : constant helper used to size the shared wait counter
// ---------------------------------------------------------------------------
package jtframe_sdram_pkg;

    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_STOP      = 4'b0110;
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_INHIBIT   = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_PRE   = 3'd2,
        ST_PWAIT = 3'd3,
        ST_REF   = 3'd4,
        ST_RWAIT = 3'd5
    } rfsh_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/jtframe_sdram_rfsh_cnt.sv
// ---------------------------------------------------------------------------
// jtframe_sdram_rfsh_cnt
// Saturating refresh-credit accumulator.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : credit strobe, only its rising edge adds RFSHCNT credits
//   dec           : one refresh was issued this cycle, consume one credit
//   pending       : registered credit count (saturates at PEND_MAX)
//   pend_nz_next  : credit count that will be loaded at the next edge is
//                   non-zero (lets the scheduler decide without waiting)
//   urgent        : registered (pending >= URG_TH), aligned with pending
// Optional (JTFRAME_SDRAM_RFSH_OVF_EN defined):
//   ovf           : one-cycle pulse when an add saturates (credits lost)
//   ovf_cnt       : number of such events, saturating at 255
// ---------------------------------------------------------------------------
module jtframe_sdram_rfsh_cnt
    import jtframe_sdram_pkg::*;
#(
    parameter int RFSHCNT  = 9,
    parameter int PEND_MAX = 31,
    parameter int URG_TH   = 16,
    parameter int PW       = $clog2(PEND_MAX + 1)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          dec,
    output logic [PW-1:0] pending,
    output logic          pend_nz_next,
    output logic          urgent
`ifdef JTFRAME_SDRAM_RFSH_OVF_EN
    ,
    output logic          ovf,
    output logic [7:0]    ovf_cnt
`endif
);

    // One extra bit so that pending+RFSHCNT never wraps before the
    // saturation compare.
    localparam logic [PW:0] ADD_W = (PW + 1)'(RFSHCNT);
    localparam logic [PW:0] MAX_W = (PW + 1)'(PEND_MAX);
    localparam logic [PW:0] URG_W = (PW + 1)'(URG_TH);
    localparam logic [PW:0] ONE_W = (PW + 1)'(1);

    logic          last_start_q, last_start_d;
    logic [PW-1:0] pending_q,    pending_d;
    logic          urgent_q,     urgent_d;
    logic          add;
    logic          sat;
    logic [PW:0]   sum;

    always_comb begin
        add          = start & ~last_start_q;
        last_start_d = start;
        sum          = {1'b0, pending_q};
        if (add) begin
            sum = sum + ADD_W;
        end
        // The scheduler never refreshes with zero credits, but guard the
        // subtraction so a stray dec can not wrap the counter.
        if (dec && (pending_q != '0)) begin
            sum = sum - ONE_W;
        end
        sat       = (sum > MAX_W);
        pending_d = sat ? MAX_W[PW-1:0] : sum[PW-1:0];
        // Compare against the next value so urgent lines up with pending.
        urgent_d  = ({1'b0, pending_d} >= URG_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_start_q <= 1'b0;
            pending_q    <= '0;
            urgent_q     <= 1'b0;
        end else begin
            last_start_q <= last_start_d;
            pending_q    <= pending_d;
            urgent_q     <= urgent_d;
        end
    end

    assign pending      = pending_q;
    assign pend_nz_next = (pending_d != '0);
    assign urgent       = urgent_q;

`ifdef JTFRAME_SDRAM_RFSH_OVF_EN
    logic       ovf_q,     ovf_d;
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        // Only an add can push the sum past PEND_MAX.
        ovf_d     = add & sat;
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_d && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= 8'd0;
        end else begin
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf     = ovf_q;
    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: rtl/jtframe_sdram64_rfsh_sched.sv
// ---------------------------------------------------------------------------
// jtframe_sdram64_rfsh_sched
// SDRAM refresh scheduler living beside the 64-bit SDRAM controller.
// Credits accumulate on each start edge; when there are credits and the
// controller is idle (or credits are urgent) the bus is requested with br.
// After bg it owns the command bus (rfshing=1), issues PRECHARGE-all, waits
// TRP, then up to BATCH REFRESH commands spaced TRFC apart, and releases.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : credit strobe (edge detected)
//   idle      : controller has no pending access
//   br / bg   : bus request / bus grant (bg pulse or level)
//   rfshing   : scheduler drives cmd / sdram_a
//   urgent    : pending >= URG_TH
//   cmd       : registered {/CS,/RAS,/CAS,/WE}
//   sdram_a   : constant address with A10=1 (precharge all banks)
//   pending   : current credit count
// Optional build macro JTFRAME_SDRAM_RFSH_OVF_EN adds:
//   ovf       : pulse when credits are lost to saturation
//   ovf_cnt   : saturating count of those events
// ---------------------------------------------------------------------------
module jtframe_sdram64_rfsh_sched
    import jtframe_sdram_pkg::*;
#(
    parameter int AW       = 13,
    parameter int RFSHCNT  = 9,
    parameter int PEND_MAX = 31,
    parameter int URG_TH   = 16,
    parameter int BATCH    = 4,
    parameter int TRP      = 2,
    parameter int TRFC     = 7,
    localparam int PW      = $clog2(PEND_MAX + 1)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          idle,
    output logic          br,
    input  logic          bg,
    output logic          rfshing,
    output logic          urgent,
    output logic [3:0]    cmd,
    output logic [AW-1:0] sdram_a,
    output logic [PW-1:0] pending
`ifdef JTFRAME_SDRAM_RFSH_OVF_EN
    ,
    output logic          ovf,
    output logic [7:0]    ovf_cnt
`endif
);

    // One down-counter serves both the tRP and the tRFC waits.
    localparam int           WW      = $clog2(max2(TRP, TRFC) + 1);
    localparam logic [WW-1:0] TRP_LD  = WW'(TRP - 1);
    localparam logic [WW-1:0] TRFC_LD = WW'(TRFC - 1);
    localparam logic [WW-1:0] W_ONE   = WW'(1);
    localparam logic [3:0]    BATCH_L = 4'(BATCH);
    localparam logic [AW-1:0] A_PALL  = AW'(1) << 10;

    rfsh_state_t   state_q,   state_d;
    logic [WW-1:0] wcnt_q,    wcnt_d;
    logic [3:0]    batch_q,   batch_d;
    logic          br_q,      br_d;
    logic          rfshing_q, rfshing_d;
    logic [3:0]    cmd_q,     cmd_d;

    logic          dec;
    logic          pend_nz_next;
    logic [PW-1:0] pending_w;
    logic          urgent_w;

    // A credit is consumed in the cycle REFRESH is on the bus.
    assign dec = (state_q == ST_REF);

    jtframe_sdram_rfsh_cnt #(
        .RFSHCNT  (RFSHCNT),
        .PEND_MAX (PEND_MAX),
        .URG_TH   (URG_TH),
        .PW       (PW)
    ) u_cnt (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dec          (dec),
        .pending      (pending_w),
        .pend_nz_next (pend_nz_next),
        .urgent       (urgent_w)
`ifdef JTFRAME_SDRAM_RFSH_OVF_EN
        ,
        .ovf          (ovf),
        .ovf_cnt      (ovf_cnt)
`endif
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            batch_q   <= '0;
            br_q      <= 1'b0;
            rfshing_q <= 1'b0;
            cmd_q     <= CMD_NOP;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            batch_q   <= batch_d;
            br_q      <= br_d;
            rfshing_q <= rfshing_d;
            cmd_q     <= cmd_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        batch_d = batch_q;
        unique case (state_q)
            ST_IDLE: begin
                if ((pending_w != '0) && (idle || urgent_w)) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // br stays up until granted, regardless of idle.
                if (bg) begin
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                wcnt_d  = TRP_LD;
                state_d = (TRP == 1) ? ST_REF : ST_PWAIT;
            end
            ST_PWAIT: begin
                wcnt_d = wcnt_q - W_ONE;
                if (wcnt_q == W_ONE) begin
                    state_d = ST_REF;
                end
            end
            ST_REF: begin
                batch_d = batch_q + 4'd1;
                wcnt_d  = TRFC_LD;
                if (TRFC == 1) begin
                    // No RWAIT cycle: decide now using the post-decrement
                    // credit count.
                    if (((batch_q + 4'd1) < BATCH_L) && pend_nz_next) begin
                        state_d = ST_REF;
                    end else begin
                        state_d = ST_IDLE;
                        batch_d = '0;
                    end
                end else begin
                    state_d = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                wcnt_d = wcnt_q - W_ONE;
                if (wcnt_q == W_ONE) begin
                    if ((batch_q < BATCH_L) && (pending_w != '0)) begin
                        state_d = ST_REF;
                    end else begin
                        state_d = ST_IDLE;
                        batch_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                batch_d = '0;
            end
        endcase
    end

    // Output logic: decoded from the next state so the registered outputs
    // line up with the state they belong to (bg -> PRECHARGE in one cycle).
    always_comb begin
        br_d      = (state_d == ST_REQ);
        rfshing_d = 1'b0;
        cmd_d     = CMD_NOP;
        unique case (state_d)
            ST_PRE: begin
                rfshing_d = 1'b1;
                cmd_d     = CMD_PRECHARGE;
            end
            ST_REF: begin
                rfshing_d = 1'b1;
                cmd_d     = CMD_REFRESH;
            end
            ST_PWAIT, ST_RWAIT: begin
                rfshing_d = 1'b1;
            end
            default: begin
                rfshing_d = 1'b0;
            end
        endcase
    end

    assign br      = br_q;
    assign rfshing = rfshing_q;
    assign urgent  = urgent_w;
    assign cmd     = cmd_q;
    assign sdram_a = A_PALL;
    assign pending = pending_w;

endmodule

// File: tb/tb_jtframe_sdram64_rfsh_sched.sv
// ---------------------------------------------------------------------------
// tb_jtframe_sdram64_rfsh_sched
// Stimulus issues start pulses and bus grants; for each grant the expected
// command timeline (PRECHARGE, REFRESHes, release) is computed from the
// timing rules and pushed into a queue. An independent monitor pops an entry
// whenever the DUT puts a command on the bus or drops rfshing.
// ---------------------------------------------------------------------------
module tb_jtframe_sdram64_rfsh_sched;

    localparam int AW       = 13;
    localparam int RFSHCNT  = 9;
    localparam int PEND_MAX = 31;
    localparam int URG_TH   = 16;
    localparam int BATCH    = 4;
    localparam int TRP      = 2;
    localparam int TRFC     = 7;
    localparam int PW       = $clog2(PEND_MAX + 1);

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;

    localparam int EV_PRE = 1;
    localparam int EV_REF = 2;
    localparam int EV_REL = 3;
    localparam int EV_BAD = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          idle;
    logic          bg;
    logic          br;
    logic          rfshing;
    logic          urgent;
    logic [3:0]    cmd;
    logic [AW-1:0] sdram_a;
    logic [PW-1:0] pending;
`ifdef JTFRAME_SDRAM_RFSH_OVF_EN
    logic          ovf;
    logic [7:0]    ovf_cnt;
`endif

    jtframe_sdram64_rfsh_sched #(
        .AW(AW), .RFSHCNT(RFSHCNT), .PEND_MAX(PEND_MAX), .URG_TH(URG_TH),
        .BATCH(BATCH), .TRP(TRP), .TRFC(TRFC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .idle    (idle),
        .br      (br),
        .bg      (bg),
        .rfshing (rfshing),
        .urgent  (urgent),
        .cmd     (cmd),
        .sdram_a (sdram_a),
        .pending (pending)
`ifdef JTFRAME_SDRAM_RFSH_OVF_EN
        ,
        .ovf     (ovf),
        .ovf_cnt (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cyc;
        int pend;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  model_pend = 0;
    int  model_ovf  = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat_add(input int p, input int a);
        return (p + a > PEND_MAX) ? PEND_MAX : p + a;
    endfunction

    // Monitor: one popped expectation per observed bus event.
    initial begin
        bit  prev_rf;
        int  kind;
        ev_t e;
        prev_rf = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rf = 1'b0;
            end else begin
                kind = 0;
                if (cmd == C_PRE)                kind = EV_PRE;
                else if (cmd == C_REF)           kind = EV_REF;
                else if (cmd != C_NOP)           kind = EV_BAD;
                else if (prev_rf && !rfshing)    kind = EV_REL;
                prev_rf = rfshing;
                if (kind != 0) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event: got kind %0d at cycle %0d pend %0d, expected none",
                                 kind, cyc, pending);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != kind || e.cyc != cyc || e.pend != int'(pending) ||
                            (kind != EV_REL && rfshing !== 1'b1)) begin
                            errors++;
                            $display("FAIL bus_event: got kind %0d cyc %0d pend %0d rfshing %0b, expected kind %0d cyc %0d pend %0d",
                                     kind, cyc, pending, rfshing, e.kind, e.cyc, e.pend);
                        end else begin
                            $display("event kind %0d at cycle %0d pending %0d", kind, cyc, pending);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // One start pulse held for w cycles; counts as a single credit add.
    task automatic pulse(input int w);
        int sum;
        sum = model_pend + RFSHCNT;
        start = 1'b1;
        tick();
`ifdef JTFRAME_SDRAM_RFSH_OVF_EN
        chk("ovf_pulse", int'(ovf), (sum > PEND_MAX) ? 1 : 0);
`endif
        if (sum > PEND_MAX) model_ovf++;
        repeat (w - 1) tick();
        start = 1'b0;
        tick();
        model_pend = sat_add(model_pend, RFSHCNT);
        chk("pending_after_start", int'(pending), model_pend);
        chk("urgent_after_start", int'(urgent), (model_pend >= URG_TH) ? 1 : 0);
        $display("start pulse width %0d -> pending %0d", w, model_pend);
    endtask

    task automatic wait_br(output bit ok);
        int n;
        n = 0;
        while (br !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        ok = (br === 1'b1);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL br_timeout: got br %0b after %0d cycles, expected 1", br, n);
        end
    endtask

    // One bus grant. inj >= 0 issues a start edge coincident with REFRESH
    // number inj of this batch.
    task automatic session(input int inj);
        bit  ok;
        int  g, t, k, p, t_inj;
        wait_br(ok);
        if (!ok) return;
        repeat ($urandom_range(0, 4)) tick();
        g = cyc;
        p = model_pend;
        exp_q.push_back('{EV_PRE, g + 1, p});
        t = g + 1 + TRP;
        t_inj = -1;
        k = 0;
        while (k < BATCH && p > 0) begin
            exp_q.push_back('{EV_REF, t, p});
            p = p - 1;
            if (k == inj) begin
                t_inj = t;
                if (p + RFSHCNT > PEND_MAX) model_ovf++;
                p = sat_add(p, RFSHCNT);
            end
            t = t + TRFC;
            k++;
        end
        exp_q.push_back('{EV_REL, t, p});
        bg = 1'b1;
        tick();
        bg = 1'b0;
        if (t_inj >= 0) begin
            while (cyc < t_inj) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        while (cyc < t) tick();
        tick();
        $display("grant at cycle %0d: %0d refreshes, pending %0d -> %0d", g, k, model_pend, p);
        model_pend = p;
        chk("pending_after_batch", int'(pending), model_pend);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (model_pend > 0 && (idle || model_pend >= URG_TH) && guard < 20) begin
            session(-1);
            guard++;
        end
    endtask

    initial begin
        bit ok;
        int g;
        rst   = 1'b1;
        start = 1'b0;
        idle  = 1'b0;
        bg    = 1'b0;
        repeat (3) tick();
        chk("reset_br", int'(br), 0);
        chk("reset_rfshing", int'(rfshing), 0);
        chk("reset_urgent", int'(urgent), 0);
        chk("reset_cmd", int'(cmd), int'(C_NOP));
        chk("reset_pending", int'(pending), 0);
        chk("sdram_a_a10", int'(sdram_a), 1024);
`ifdef JTFRAME_SDRAM_RFSH_OVF_EN
        chk("reset_ovf_cnt", int'(ovf_cnt), 0);
`endif
        rst = 1'b0;
        tick();

        // Basic batch, then drain the 5 leftover credits (4 + early end at 1)
        idle = 1'b1;
        pulse(1);
        session(-1);
        chk("basic_pending_left", model_pend, 5);
        drain();

        // Idle gating and urgency
        idle = 1'b0;
        pulse(1);
        repeat (6) tick();
        chk("gated_br", int'(br), 0);
        chk("gated_urgent", int'(urgent), 0);
        pulse(2);
        wait_br(ok);
        chk("urgent_set", int'(urgent), 1);
        drain();
        repeat (6) tick();
        chk("not_urgent_br", int'(br), 0);
        idle = 1'b1;
        drain();

        // Saturation
        idle = 1'b0;
        for (int i = 0; i < 4; i++) pulse($urandom_range(1, 3));
        chk("sat_pending", int'(pending), PEND_MAX);
`ifdef JTFRAME_SDRAM_RFSH_OVF_EN
        chk("sat_ovf_cnt", int'(ovf_cnt), model_ovf);
`endif
        idle = 1'b1;
        drain();

        // Start edge coincident with a REFRESH at pending=5
        pulse(1);
        session(-1);
        session(0);
        drain();

        // Held-high start counts once
        idle = 1'b0;
        pulse(5);
        idle = 1'b1;
        drain();

        // Randomised traffic
        for (int r = 0; r < 6; r++) begin
            idle = 1'($urandom_range(0, 1));
            for (int i = 0, n = $urandom_range(1, 3); i < n; i++) pulse($urandom_range(1, 3));
            drain();
            idle = 1'b1;
            drain();
        end

        // Reset during RWAIT
        idle = 1'b1;
        pulse(1);
        wait_br(ok);
        g = cyc;
        exp_q.push_back('{EV_PRE, g + 1, model_pend});
        exp_q.push_back('{EV_REF, g + 1 + TRP, model_pend});
        bg = 1'b1;
        tick();
        bg = 1'b0;
        while (cyc < g + 1 + TRP + 2) tick();
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        model_pend = 0;
        chk("rst_cmd", int'(cmd), int'(C_NOP));
        chk("rst_rfshing", int'(rfshing), 0);
        chk("rst_br", int'(br), 0);
        chk("rst_pending", int'(pending), 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("post_rst_br", int'(br), 0);
        chk("post_rst_rfshing", int'(rfshing), 0);
        pulse(1);
        drain();

        repeat (5) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
